uart_tx_queue: RTL and testbench

- Buffers ASCII bytes produced by the keyboard path (Ps2StateMachine / ScanCodeToAscii) and feeds them one at a time to async_transmitter.
- Replaces the direct scan_code_ready -> TxD_start wiring, which drops keystrokes that arrive while the transmitter is busy.
- Sits in the clk100M domain, directly upstream of the UART transmitter.

---
 rtl/uart_tx_queue_pkg.sv | 26 ++
 rtl/uart_tx_queue_if.sv | 30 +++
 rtl/uart_tx_queue_byte_fifo.sv | 77 +++++++
 rtl/uart_tx_queue.sv | 139 +++++++++++++
 tb/tb_uart_tx_queue.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared types for the UART transmit queue: byte type, transmit FSM states and
// the saturating drop-counter increment.
package uart_tx_queue_pkg;

    localparam int UTQ_DATA_WIDTH = 8;

    typedef logic [UTQ_DATA_WIDTH-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } UartTxState_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between the keyboard/transmitter side (master) and the
// transmit queue (slave).
interface uart_tx_queue_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  inValid;
    logic [DATA_WIDTH-1:0] inData;
    logic                  txBusy;
    logic                  txStart;
    logic [DATA_WIDTH-1:0] txData;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [7:0]            dropCount;

    modport master (
        output inValid, inData, txBusy,
        input  txStart, txData, full, empty, count, overflow, dropCount
    );

    modport slave (
        input  inValid, inData, txBusy,
        output txStart, txData, full, empty, count, overflow, dropCount
    );

endinterface

// File: rtl/uart_tx_queue_byte_fifo.sv
// Power-of-two circular FIFO with a combinational head read and a true
// occupancy count (0..DEPTH).
module byte_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == {CW{1'b0}});
    assign count_o  = count_q;
    assign dout_o   = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Queues keyboard ASCII bytes and launches them one at a time into the UART
// transmitter, holding off while the transmitter reports busy.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int DROP_NUL     = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic              clk,
    input logic              rst,
    uart_tx_queue_if.slave   bus
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [3:0]  TO_LIMIT = 4'(BUSY_TIMEOUT);

    UartTxState_t          state_q, state_d;
    logic [3:0]            to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;

    logic                  nul_s, push_s, pop_s, drop_s, tx_start_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (bus.inData),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Unmapped keys arrive as NUL and vanish silently rather than counting as drops.
    assign nul_s  = (DROP_NUL != 0) && (bus.inData == {DATA_WIDTH{1'b0}});
    assign push_s = bus.inValid && !nul_s && (!fifo_full_s || pop_s);
    assign drop_s = bus.inValid && !nul_s && fifo_full_s && !pop_s;

    // FSM state and busy-timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            to_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // FSM next-state; a transmitter that never raises busy is treated as done.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d  = WAIT_BUSY;
                to_cnt_d = 4'd0;
            end
            WAIT_BUSY: begin
                if (bus.txBusy) begin
                    state_d = WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
                    if (to_cnt_d == TO_LIMIT) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_BUSY;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.txBusy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the busy check in IDLE covers a transmitter still busy after reset.
    always_comb begin
        pop_s      = 1'b0;
        tx_start_s = 1'b0;
        case (state_q)
            IDLE:    pop_s      = !fifo_empty_s && !bus.txBusy;
            START:   tx_start_s = 1'b1;
            default: begin
                pop_s      = 1'b0;
                tx_start_s = 1'b0;
            end
        endcase
    end

    // Transmit byte capture plus overflow pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q  <= {DATA_WIDTH{1'b0}};
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            overflow_q <= drop_s;
            if (pop_s) begin
                tx_data_q <= fifo_head_s;
            end
            if (drop_s) begin
                drop_cnt_q <= sat_inc8(drop_cnt_q);
            end
        end
    end

    assign bus.txStart   = tx_start_s;
    assign bus.txData    = tx_data_q;
    assign bus.full      = fifo_full_s;
    assign bus.empty     = fifo_empty_s;
    assign bus.count     = fifo_count_s;
    assign bus.overflow  = overflow_q;
    assign bus.dropCount = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a small transmitter model that raises
// busy one cycle after each start pulse.
module tb_uart_tx_queue;
    import uart_tx_queue_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(8)) bus ();

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .DATA_WIDTH   (8),
        .DROP_NUL     (1),
        .BUSY_TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    vectors       = 0;
    int    miscompares   = 0;
    int    cyc           = 0;
    int    last_push_cyc = 0;
    int    ovf_cnt       = 0;
    byte_t tx_data_log[$];
    int    tx_cyc_log[$];

    logic  model_on   = 1'b1;
    int    busy_len   = 10;
    logic  hold_busy  = 1'b0;
    logic  model_busy = 1'b0;
    logic  arm        = 1'b0;
    int    busy_left  = 0;

    assign bus.txBusy = model_busy | hold_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises the cycle after txStart and lasts busy_len cycles.
    always @(negedge clk) begin
        if (!model_on) begin
            arm        <= 1'b0;
            busy_left  <= 0;
            model_busy <= 1'b0;
        end else begin
            if (arm) begin
                model_busy <= 1'b1;
                busy_left  <= busy_len;
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) model_busy <= 1'b0;
            end
            arm <= (bus.txStart === 1'b1);
        end
    end

    always @(negedge clk) begin
        if (bus.txStart === 1'b1) begin
            tx_data_log.push_back(bus.txData);
            tx_cyc_log.push_back(cyc);
        end
        if (bus.overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_steps(input int n);
        repeat (n) step();
    endtask

    task automatic push_byte(input byte_t b);
        bus.inValid = 1'b1;
        bus.inData  = b;
        step();
        last_push_cyc = cyc;
    endtask

    task automatic end_push();
        bus.inValid = 1'b0;
        bus.inData  = 8'h00;
    endtask

    int b0, p0, ovf0, rel;
    byte_t exp_b;

    initial begin
        bus.inValid = 1'b0;
        bus.inData  = 8'h00;

        // Reset state
        step();
        check("rst_txStart", 32'(bus.txStart), 32'd0);
        check("rst_txData", 32'(bus.txData), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_dropCount", 32'(bus.dropCount), 32'd0);
        rst = 1'b0;
        step();

        // 1: single byte
        b0 = tx_data_log.size();
        push_byte(8'h41);
        end_push();
        p0 = last_push_cyc;
        check("t1_count_after_push", 32'(bus.count), 32'd1);
        wait_steps(20);
        check("t1_ntx", 32'(tx_data_log.size() - b0), 32'd1);
        if (tx_data_log.size() > b0) begin
            check("t1_data", 32'(tx_data_log[b0]), 32'h41);
            check("t1_latency", 32'(tx_cyc_log[b0] - p0), 32'd1);
        end
        check("t1_count_end", 32'(bus.count), 32'd0);
        check("t1_empty_end", 32'(bus.empty), 32'd1);

        // 2: burst while busy
        busy_len = 20;
        step();
        b0 = tx_data_log.size();
        ovf0 = ovf_cnt;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        end_push();
        wait_steps(90);
        check("t2_ntx", 32'(tx_data_log.size() - b0), 32'd3);
        if (tx_data_log.size() >= b0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                exp_b = 8'h61 + 8'(i);
                check($sformatf("t2_data%0d", i), 32'(tx_data_log[b0+i]), 32'(exp_b));
            end
            check("t2_gap01", 32'(tx_cyc_log[b0+1] - tx_cyc_log[b0]), 32'd23);
            check("t2_gap12", 32'(tx_cyc_log[b0+2] - tx_cyc_log[b0+1]), 32'd23);
        end
        check("t2_dropCount", 32'(bus.dropCount), 32'd0);
        check("t2_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd0);

        // 3: overflow while held busy, saturation, then drain with push on the pop edge
        busy_len  = 3;
        hold_busy = 1'b1;
        b0 = tx_data_log.size();
        ovf0 = ovf_cnt;
        for (int i = 0; i < DEPTH + 3; i++) push_byte(8'h10 + 8'(i));
        end_push();
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_count", 32'(bus.count), 32'(DEPTH));
        check("t3_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd3);
        check("t3_dropCount", 32'(bus.dropCount), 32'd3);
        for (int i = 0; i < 253; i++) push_byte(8'h55);
        end_push();
        check("t3_dropCount_sat", 32'(bus.dropCount), 32'd255);
        check("t3_ovf_pulses_all", 32'(ovf_cnt - ovf0), 32'd256);
        hold_busy = 1'b0;
        push_byte(8'hAA);
        end_push();
        check("t3_count_pushpop", 32'(bus.count), 32'(DEPTH));
        check("t3_full_pushpop", 32'(bus.full), 32'd1);
        check("t3_overflow_pushpop", 32'(bus.overflow), 32'd0);
        wait_steps(100);
        check("t3_ntx", 32'(tx_data_log.size() - b0), 32'(DEPTH + 1));
        if (tx_data_log.size() >= b0 + DEPTH + 1) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_b = 8'h10 + 8'(i);
                check($sformatf("t3_data%0d", i), 32'(tx_data_log[b0+i]), 32'(exp_b));
            end
            check("t3_data_last", 32'(tx_data_log[b0+DEPTH]), 32'hAA);
        end
        check("t3_empty_end", 32'(bus.empty), 32'd1);
        check("t3_dropCount_hold", 32'(bus.dropCount), 32'd255);

        // 4: NUL filter (fresh reset clears the drop counter)
        rst = 1'b1;
        wait_steps(2);
        rst = 1'b0;
        step();
        check("t4_dropCount_rst", 32'(bus.dropCount), 32'd0);
        b0 = tx_data_log.size();
        ovf0 = ovf_cnt;
        push_byte(8'h00);
        check("t4_count_nul", 32'(bus.count), 32'd0);
        push_byte(8'h0D);
        end_push();
        check("t4_count_cr", 32'(bus.count), 32'd1);
        wait_steps(20);
        check("t4_ntx", 32'(tx_data_log.size() - b0), 32'd1);
        if (tx_data_log.size() > b0) check("t4_data", 32'(tx_data_log[b0]), 32'h0D);
        check("t4_dropCount", 32'(bus.dropCount), 32'd0);
        check("t4_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd0);

        // 5: busy timeout, transmitter never answers
        model_on = 1'b0;
        step();
        b0 = tx_data_log.size();
        push_byte(8'hA1);
        p0 = last_push_cyc;
        push_byte(8'hA2);
        end_push();
        wait_steps(25);
        check("t5_ntx", 32'(tx_data_log.size() - b0), 32'd2);
        if (tx_data_log.size() >= b0 + 2) begin
            check("t5_data0", 32'(tx_data_log[b0]), 32'hA1);
            check("t5_data1", 32'(tx_data_log[b0+1]), 32'hA2);
            check("t5_latency", 32'(tx_cyc_log[b0] - p0), 32'd1);
            check("t5_gap", 32'(tx_cyc_log[b0+1] - tx_cyc_log[b0]), 32'(TIMEOUT + 2));
        end
        check("t5_empty_end", 32'(bus.empty), 32'd1);

        // 6: asynchronous reset during WAIT_DONE with bytes queued
        model_on = 1'b1;
        busy_len = 30;
        step();
        b0 = tx_data_log.size();
        for (int i = 0; i < 6; i++) push_byte(8'hB1 + 8'(i));
        end_push();
        wait_steps(3);
        check("t6_count_queued", 32'(bus.count), 32'd5);
        check("t6_busy_before", 32'(bus.txBusy), 32'd1);
        hold_busy = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_empty", 32'(bus.empty), 32'd1);
        check("t6_async_count", 32'(bus.count), 32'd0);
        check("t6_async_full", 32'(bus.full), 32'd0);
        check("t6_async_txStart", 32'(bus.txStart), 32'd0);
        check("t6_async_txData", 32'(bus.txData), 32'd0);
        check("t6_async_overflow", 32'(bus.overflow), 32'd0);
        model_on = 1'b0;
        wait_steps(2);
        rst = 1'b0;
        step();
        push_byte(8'hC7);
        end_push();
        wait_steps(10);
        check("t6_held_ntx", 32'(tx_data_log.size() - b0), 32'd1);
        check("t6_held_count", 32'(bus.count), 32'd1);
        if (tx_data_log.size() > b0) check("t6_first_data", 32'(tx_data_log[b0]), 32'hB1);
        hold_busy = 1'b0;
        rel = cyc;
        wait_steps(5);
        check("t6_ntx", 32'(tx_data_log.size() - b0), 32'd2);
        if (tx_data_log.size() >= b0 + 2) begin
            check("t6_data", 32'(tx_data_log[b0+1]), 32'hC7);
            check("t6_launch", 32'(tx_cyc_log[b0+1] - rel), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
